// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Central stall/flush sequencer for a 5-stage pipeline. It owns the write
// enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB and the flushes of IF/ID and
// ID/EX. It handles three cases:
//   - variable-latency data-memory access through a req/ack handshake in MEM
//   - load-use stalls detected in ID
//   - taken-branch flushes
// A memory access that never completes is caught by a timeout. The timeout
// freezes the pipeline in HALT until the next reset.
//
// Optional feature macro: PIPE_STALL_PERF_EN. When it is defined, the block
// gains the 32-bit saturating stall-cycle counter output stall_cyc_o.
//
// Ports:
//   clk_i             clock, rising edge
//   rst_i             synchronous active-low reset
//   memop_i           EX/MEM holds a load or store
//   mem_ack_i         data memory completes the access this cycle
//   mem_req_o         data-memory request (level, held until ack)
//   id_ex_memread_i   ID/EX holds a load
//   id_ex_rt_i        load destination register in ID/EX
//   if_id_rs_i        rs of the instruction in IF/ID
//   if_id_rt_i        rt of the instruction in IF/ID
//   branch_taken_i    branch in ID resolved taken
//   pc_we_o .. mem_wb_we_o   pipeline register enables
//   if_id_flush_o     clear IF/ID to NOP on the next edge
//   id_ex_flush_o     clear ID/EX control bits (bubble) on the next edge
//   timeout_o         sticky hang flag
//   state_o           FSM state (RUN=0, MEM_WAIT=1, HALT=2)
//   stall_cyc_o       (PIPE_STALL_PERF_EN only) cycles with pc_we_o low
module pipe_stall_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       memop_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    input  logic       id_ex_memread_i,
    input  logic [4:0] id_ex_rt_i,
    input  logic [4:0] if_id_rs_i,
    input  logic [4:0] if_id_rt_i,
    input  logic       branch_taken_i,
    output logic       pc_we_o,
    output logic       if_id_we_o,
    output logic       id_ex_we_o,
    output logic       ex_mem_we_o,
    output logic       mem_wb_we_o,
    output logic       if_id_flush_o,
    output logic       id_ex_flush_o,
    output logic       timeout_o,
    output logic [1:0] state_o
`ifdef PIPE_STALL_PERF_EN
    ,
    output logic [31:0] stall_cyc_o
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    // Counter value seen on the last permitted MEM_WAIT cycle.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       timeout_q;
    logic       timeout_set;
    logic       load_use;

    // r0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = id_ex_memread_i && (id_ex_rt_i != 5'd0) &&
                      ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

    always_comb begin
        pc_we_o       = 1'b0;
        if_id_we_o    = 1'b0;
        id_ex_we_o    = 1'b0;
        ex_mem_we_o   = 1'b0;
        mem_wb_we_o   = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        mem_req_o     = 1'b0;
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        timeout_set   = 1'b0;

        // While reset is asserted every control output stays low, so an
        // outstanding request is dropped in the same cycle.
        if (rst_i) begin
            case (state)
                ST_RUN: begin
                    if (memop_i) begin
                        // Detect cycle: freeze everything; the request goes
                        // out from MEM_WAIT so it never appears in RUN.
                        state_nxt    = ST_MEM_WAIT;
                        wait_cnt_nxt = 8'd0;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, and push a bubble into ID/EX.
                        // The branch is ignored here and re-resolves after the stall.
                        id_ex_we_o    = 1'b1;
                        ex_mem_we_o   = 1'b1;
                        mem_wb_we_o   = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else begin
                        pc_we_o       = 1'b1;
                        if_id_we_o    = 1'b1;
                        id_ex_we_o    = 1'b1;
                        ex_mem_we_o   = 1'b1;
                        mem_wb_we_o   = 1'b1;
                        if_id_flush_o = branch_taken_i;
                    end
                end
                ST_MEM_WAIT: begin
                    mem_req_o = 1'b1;
                    if (mem_ack_i) begin
                        // Everything advances so MEM/WB captures the read data.
                        pc_we_o     = 1'b1;
                        if_id_we_o  = 1'b1;
                        id_ex_we_o  = 1'b1;
                        ex_mem_we_o = 1'b1;
                        mem_wb_we_o = 1'b1;
                        state_nxt   = ST_RUN;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state_nxt   = ST_HALT;
                        timeout_set = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end
                ST_HALT: begin
                    state_nxt = ST_HALT;
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= ST_RUN;
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
    assign state_o   = state;

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] stall_cyc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cyc_q <= 32'd0;
        end else if (!pc_we_o && (stall_cyc_q != 32'hFFFF_FFFF)) begin
            stall_cyc_q <= stall_cyc_q + 32'd1;
        end
    end

    assign stall_cyc_o = stall_cyc_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    localparam int unsigned TMO = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       memop_i;
    logic       mem_ack_i;
    logic       mem_req_o;
    logic       id_ex_memread_i;
    logic [4:0] id_ex_rt_i;
    logic [4:0] if_id_rs_i;
    logic [4:0] if_id_rt_i;
    logic       branch_taken_i;
    logic       pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o;
    logic       if_id_flush_o, id_ex_flush_o;
    logic       timeout_o;
    logic [1:0] state_o;
`ifdef PIPE_STALL_PERF_EN
    logic [31:0] stall_cyc_o;
`endif

    pipe_stall_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .memop_i         (memop_i),
        .mem_ack_i       (mem_ack_i),
        .mem_req_o       (mem_req_o),
        .id_ex_memread_i (id_ex_memread_i),
        .id_ex_rt_i      (id_ex_rt_i),
        .if_id_rs_i      (if_id_rs_i),
        .if_id_rt_i      (if_id_rt_i),
        .branch_taken_i  (branch_taken_i),
        .pc_we_o         (pc_we_o),
        .if_id_we_o      (if_id_we_o),
        .id_ex_we_o      (id_ex_we_o),
        .ex_mem_we_o     (ex_mem_we_o),
        .mem_wb_we_o     (mem_wb_we_o),
        .if_id_flush_o   (if_id_flush_o),
        .id_ex_flush_o   (id_ex_flush_o),
        .timeout_o       (timeout_o),
        .state_o         (state_o)
`ifdef PIPE_STALL_PERF_EN
        ,
        .stall_cyc_o     (stall_cyc_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_state;
    int          m_cnt;
    logic        m_tmo;
    logic [31:0] m_perf;

    // Scoreboard: expected output vector and expected perf count per cycle
    logic [11:0] exp_q[$];
    logic [31:0] perf_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Vector order: pc, if_id, id_ex, ex_mem, mem_wb, if_flush, idex_flush, req, timeout, state[1:0]
    function automatic logic [11:0] model_out();
        logic [6:0] en_fl;
        logic       req;
        logic       hz;
        en_fl = 7'b0;
        req   = 1'b0;
        hz    = id_ex_memread_i && id_ex_rt_i != 0 &&
                (id_ex_rt_i == if_id_rs_i || id_ex_rt_i == if_id_rt_i);
        if (rst_i) begin
            if (m_state == 0) begin
                if (memop_i)      en_fl = 7'b0000000;
                else if (hz)      en_fl = 7'b0011101;
                else              en_fl = {5'b11111, branch_taken_i, 1'b0};
            end else if (m_state == 1) begin
                req = 1'b1;
                if (mem_ack_i)    en_fl = 7'b1111100;
            end
        end
        return {en_fl, req, m_tmo, 2'(m_state)};
    endfunction

    task automatic model_edge(input logic pc_we_exp);
        if (!rst_i) begin
            m_state = 0; m_cnt = 0; m_tmo = 1'b0; m_perf = 0;
        end else begin
            if (!pc_we_exp && m_perf != 32'hFFFF_FFFF) m_perf++;
            case (m_state)
                0: if (memop_i) begin m_state = 1; m_cnt = 0; end
                1: begin
                    if (mem_ack_i)              m_state = 0;
                    else if (m_cnt == TMO - 1)  begin m_state = 2; m_tmo = 1'b1; end
                    else                        m_cnt++;
                end
                default: ;
            endcase
        end
    endtask

    // Called just after a rising edge: drive, predict, compare at the falling edge.
    task automatic step(input string tag, input logic r, input logic m, input logic a,
                        input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic b);
        logic [11:0] e;
        logic [11:0] act;
        rst_i = r; memop_i = m; mem_ack_i = a; id_ex_memread_i = mr;
        id_ex_rt_i = ert; if_id_rs_i = rs; if_id_rt_i = rt; branch_taken_i = b;
        exp_q.push_back(model_out());
        perf_q.push_back(m_perf);
        @(negedge clk_i);
        e   = exp_q.pop_front();
        act = {pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o,
               if_id_flush_o, id_ex_flush_o, mem_req_o, timeout_o, state_o};
        check_eq(tag, 32'(act), 32'(e));
`ifdef PIPE_STALL_PERF_EN
        check_eq({tag, "_perf"}, stall_cyc_o, perf_q.pop_front());
`else
        void'(perf_q.pop_front());
`endif
        model_edge(e[11]);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0; memop_i = 1'b0; mem_ack_i = 1'b0; id_ex_memread_i = 1'b0;
        id_ex_rt_i = 5'd0; if_id_rs_i = 5'd0; if_id_rt_i = 5'd0; branch_taken_i = 1'b0;
        m_state = 0; m_cnt = 0; m_tmo = 1'b0; m_perf = 0;
        repeat (2) @(posedge clk_i);
        #1;

        step("reset",    0, 0, 0, 0, 0, 0, 0, 0);
        step("idle",     1, 0, 0, 0, 0, 0, 0, 0);
        step("idle_br",  1, 0, 0, 0, 0, 0, 0, 1);

        // Memory op, ack three cycles after the request rises
        step("mem_det",  1, 1, 0, 0, 0, 0, 0, 0);
        step("mem_w1",   1, 1, 0, 0, 0, 0, 0, 0);
        step("mem_w2",   1, 1, 0, 0, 0, 0, 0, 0);
        step("mem_w3",   1, 1, 0, 0, 0, 0, 0, 0);
        step("mem_ack",  1, 1, 1, 0, 0, 0, 0, 0);
`ifdef PIPE_STALL_PERF_EN
        check_eq("perf_mem4", stall_cyc_o, 32'd4);
`endif
        step("mem_done", 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("mem_req_low", 32'(mem_req_o), 32'd0);

        // Load-use stall beats a taken branch; rt=0 means no hazard
        step("lu_rs",    1, 0, 0, 1, 5, 5, 0, 1);
        step("lu_after", 1, 0, 0, 0, 5, 5, 0, 0);
        step("lu_rt",    1, 0, 0, 1, 7, 1, 7, 0);
        step("lu_r0",    1, 0, 0, 1, 0, 0, 0, 1);
        check_eq("lu_r0_flush", 32'(if_id_flush_o), 32'd1);

        // Ack already high in RUN is ignored
        step("eack_det", 1, 1, 1, 0, 0, 0, 0, 0);
        step("eack_w1",  1, 1, 1, 0, 0, 0, 0, 0);
        step("eack_run", 1, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-wait
        step("rmw_det",  1, 1, 0, 0, 0, 0, 0, 0);
        step("rmw_w1",   1, 1, 0, 0, 0, 0, 0, 0);
        step("rmw_rst",  0, 1, 0, 0, 0, 0, 0, 0);
        step("rmw_post", 1, 0, 0, 0, 0, 0, 0, 0);

        // Timeout with no ack, then a late ack
        step("to_det",   1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < TMO; i++) step("to_wait", 1, 1, 0, 0, 0, 0, 0, 0);
        check_eq("halt_state", 32'(state_o), 32'd2);
        check_eq("halt_tmo",   32'(timeout_o), 32'd1);
        step("halt_late_ack", 1, 1, 1, 0, 0, 0, 0, 0);
        step("halt_hold",     1, 0, 1, 1, 3, 3, 0, 1);
        check_eq("halt_stays", 32'(state_o), 32'd2);
        step("halt_rst",      0, 0, 0, 0, 0, 0, 0, 0);
        step("halt_clear",    1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("tmo_cleared", 32'(timeout_o), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            step("rand",
                 ($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enables of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the flushes for IF/ID and ID/EX. It handles three things: variable-latency data-memory access through a req/ack handshake in MEM, load-use stalls in ID, and taken-branch flushes. A hung memory access is detected by a timeout and freezes the pipeline.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in MEM_WAIT before declaring a hang (legal range 1..255).

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-low reset
- memop_i  in  1  EX/MEM currently holds a load or store
- mem_ack_i  in  1  data memory has completed the access this cycle
- mem_req_o  out  1  data-memory request, level, held until ack
- id_ex_memread_i  in  1  ID/EX holds a load
- id_ex_rt_i  in  5  load destination register in ID/EX
- if_id_rs_i  in  5  rs of instruction in IF/ID
- if_id_rt_i  in  5  rt of instruction in IF/ID
- branch_taken_i  in  1  branch in ID resolved taken
- pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o  out  1 each  register enables
- if_id_flush_o  out  1  clear IF/ID to NOP on next edge
- id_ex_flush_o  out  1  clear ID/EX control bits (bubble) on next edge
- timeout_o  out  1  sticky hang flag
- state_o  out  2  current FSM state (RUN=0, MEM_WAIT=1, HALT=2)

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Registered: state, 8-bit wait counter, timeout_o, optional perf counter. All other outputs are combinational from state and inputs.
- RUN with memop_i=1:
  - all five enables 0, both flushes 0
  - next state MEM_WAIT, counter cleared to 0
- MEM_WAIT:
  - mem_req_o=1.
  - If mem_ack_i=1: all enables 1, so MEM/WB captures the memory data. Next state RUN.
  - Else: all enables 0 and the counter increments.
  - If the counter equals TIMEOUT_CYCLES-1 with no ack: next state HALT, timeout_o set.
- HALT:
  - all enables 0, mem_req_o=0, flushes 0
  - mem_ack_i ignored; state is left only by reset
- RUN with memop_i=0 and a load-use hazard (id_ex_memread_i=1, id_ex_rt_i≠0, and id_ex_rt_i equal to if_id_rs_i or if_id_rt_i):
  - pc_we_o=0, if_id_we_o=0, id_ex_flush_o=1
  - ex_mem_we_o=1, mem_wb_we_o=1
  - branch_taken_i ignored this cycle; the branch re-resolves after the stall
- RUN with no memop and no hazard:
  - all enables 1
  - if_id_flush_o=branch_taken_i
- Priority: HALT > memory wait > load-use > branch flush.
- Reset: rst_i=0 forces state RUN, counter 0, timeout_o 0. During that cycle all enables, flushes and mem_req_o are 0. Reset asserted mid-MEM_WAIT drops mem_req_o in the same cycle; the memory side must tolerate the aborted request.

## Timing
- Memory op latency: 1 detect cycle (RUN) + N wait cycles; the pipeline advances on the ack cycle.
  - Ack on the first MEM_WAIT cycle gives a 2-cycle MEM stage.
- mem_req_o rises the cycle after memop_i is seen in RUN and falls the cycle after ack. It is never asserted in RUN.
- mem_ack_i outside MEM_WAIT is ignored.
- Back-to-back memops: after the ack cycle the new EX/MEM content is evaluated in RUN on the next cycle, which gives a fresh detect cycle. There is no request overlap.
- Load-use stall costs exactly 1 cycle. On the following cycle the loaded value comes from MEM, and the hazard check clears.
- Timeout: HALT is entered on the edge ending MEM_WAIT cycle TIMEOUT_CYCLES. timeout_o is visible on the next cycle.

## Configuration
- PIPE_STALL_PERF_EN defined:
  - adds output stall_cyc_o (32 bits), reset to 0
  - increments every cycle pc_we_o=0 while not in reset, including HALT
  - saturates at 0xFFFFFFFF
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Release reset, memop_i=0, no hazard, branch 0 → all enables 1, flushes 0, mem_req_o 0, state_o 0.
- memop_i=1, ack 3 cycles after req rises → 1 detect + 3 frozen cycles, then enables 1 on the ack cycle, mem_req_o 0 next cycle, state_o back to 0. With perf enabled, stall_cyc_o=4.
- id_ex_memread_i=1, id_ex_rt_i=5, if_id_rs_i=5, branch_taken_i=1 → pc_we_o=0, if_id_we_o=0, id_ex_flush_o=1, if_id_flush_o=0 for one cycle. Same stimulus with id_ex_rt_i=0 → no stall and if_id_flush_o=1.
- TIMEOUT_CYCLES=4, memop_i=1, no ack → HALT after 4 MEM_WAIT cycles, timeout_o=1, mem_req_o=0. A late ack is ignored and state_o stays 2.
- Reset pulse (rst_i=0 for 1 cycle) during MEM_WAIT → mem_req_o 0 that cycle, state_o 0 and timeout_o 0 afterwards.
- memop_i=1 with mem_ack_i already high in RUN → ack ignored. Req issued next cycle; completes in MEM_WAIT on the first ack.
